sa_fifo_ctrl_19x4: RTL and testbench

- Valid/ready FIFO controller that drives the read and write ports of an external 19-entry x 4-bit two-port RAM: read/write addresses and enables, output-register enable, bypass select/data, and the power bus.
- The RAM has a registered read address and a registered output (`ore`). This block sequences that two-stage read pipeline so it looks like a simple FIFO with one output register.
- Sits between a producer pipe and a consumer pipe in the systolic-array datapath. Total capacity is 20 entries: 19 in RAM plus 1 in the RAM output register.

---
 rtl/sa_fifo_ctrl_19x4_if.sv | 58 +++++
 rtl/sa_fifo_ctrl_19x4.sv | 127 ++++++++++++
 tb/tb_sa_fifo_ctrl_19x4.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_fifo_ctrl_19x4_if.sv
// sa_fifo_ctrl_19x4_if: producer/consumer handshakes, external RAM port
// bus and power bus for the 19x4 FIFO controller.
//
// Handshake semantics (both wr_* and rd_* pipes): a beat transfers on a
// rising clk edge where pvld and prdy are both 1. A source that raises
// pvld holds it and its payload stable until that transfer; prdy may
// change freely and never depends combinationally on pvld of the same pipe.
//
// Modports:
//   slave  - the FIFO controller (accepts from the producer, serves the
//            consumer, drives the RAM ports).
//   master - the surroundings (producer, consumer and the RAM macro).
interface sa_fifo_ctrl_19x4_if;

  // Producer pipe
  logic        wr_pvld;
  logic        wr_prdy;
  logic [3:0]  wr_pd;

  // Consumer pipe
  logic        rd_pvld;
  logic        rd_prdy;
  logic [3:0]  rd_pd;

  // RAM read port (registered address, registered output)
  logic [4:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [3:0]  ram_dout;

  // RAM write port and output-register bypass
  logic [4:0]  ram_wa;
  logic        ram_we;
  logic [3:0]  ram_di;
  logic        ram_byp_sel;
  logic [3:0]  ram_dbyp;

  // Power bus
  logic [31:0] pwrbus_ram_pd;
  logic [31:0] ram_pwrbus_ram_pd;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
    output wr_prdy, rd_pvld, rd_pd,
    output ram_ra, ram_re, ram_ore,
    output ram_wa, ram_we, ram_di, ram_byp_sel, ram_dbyp,
    output ram_pwrbus_ram_pd
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
    input  wr_prdy, rd_pvld, rd_pd,
    input  ram_ra, ram_re, ram_ore,
    input  ram_wa, ram_we, ram_di, ram_byp_sel, ram_dbyp,
    input  ram_pwrbus_ram_pd
  );

endinterface

// File: rtl/sa_fifo_ctrl_19x4.sv
// sa_fifo_ctrl_19x4: valid/ready FIFO controller for an external 19x4
// two-port RAM with registered read address and registered output.
// The two-stage RAM read (address latch, then output register) is
// sequenced so the block behaves as a 20-entry FIFO: 19 entries in RAM
// plus one in the RAM output register, which is the FIFO output stage.
//
// Optional feature macro: SA_FIFO_CTRL_BYPASS_EN
//   defined   - a write into a completely empty FIFO whose output stage is
//               free goes straight into the RAM output register through
//               the bypass path (1-cycle push-to-valid latency).
//   undefined - ram_byp_sel is tied to 0; every beat goes through the RAM
//               (3-cycle push-to-valid latency).
module sa_fifo_ctrl_19x4 (
  input  logic                 clk,
  input  logic                 rst,
  sa_fifo_ctrl_19x4_if.slave   bus
);

  localparam int DEPTH = 19;
  localparam int AW    = 5;
  localparam int DW    = 4;

  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] USED_FULL = AW'(DEPTH);

  // State
  logic [AW-1:0] wptr_q, wptr_d;     // next RAM write address
  logic [AW-1:0] rptr_q, rptr_d;     // next RAM read address to issue
  logic [AW-1:0] used_q, used_d;     // entries in RAM not yet captured by ore
  logic          s1_vld_q, s1_vld_d; // RAM holds a latched read address
  logic          rd_pvld_q, rd_pvld_d;

  // Datapath control
  logic          out_free;  // output register can take a new entry
  logic          wr_prdy_c;
  logic          wr_acc;    // producer beat accepted this cycle
  logic          byp;       // accepted beat goes through the bypass path
  logic          ore;       // load the RAM output register
  logic          we;        // write the accepted beat into RAM
  logic [AW-1:0] pend;      // entries in RAM whose address is not yet issued
  logic          re;        // issue the next read address

  // Handshake decode and RAM port control.
  always_comb begin
    out_free  = !rd_pvld_q | bus.rd_prdy;
    wr_prdy_c = !rst & (used_q < USED_FULL);
    wr_acc    = bus.wr_pvld & wr_prdy_c;
`ifdef SA_FIFO_CTRL_BYPASS_EN
    // Only when nothing is stored in RAM or in flight can a new beat skip
    // the RAM without overtaking older data.
    byp       = wr_acc & (used_q == '0) & !s1_vld_q & out_free;
`else
    byp       = 1'b0;
`endif
    ore       = (s1_vld_q & out_free) | byp;
    we        = wr_acc & !byp;
    pend      = used_q - {{(AW-1){1'b0}}, s1_vld_q};
    // A new address may only be latched when the previous one is consumed
    // on this edge (or there is none), otherwise its data would be lost.
    re        = (pend != '0) & (!s1_vld_q | ore);
  end

  // Next-state computation for pointers, occupancy and pipeline valids.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    s1_vld_d  = s1_vld_q;
    used_d    = used_q;
    rd_pvld_d = rd_pvld_q;

    if (we) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
    end
    if (re) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + AW'(1);
    end

    s1_vld_d  = re | (s1_vld_q & !ore);
    // Bypass beats never occupy RAM, so only RAM-sourced ore frees a slot.
    used_d    = used_q + {{(AW-1){1'b0}}, we}
                       - {{(AW-1){1'b0}}, (ore & !byp)};
    rd_pvld_d = ore | (rd_pvld_q & !bus.rd_prdy);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      used_q    <= '0;
      s1_vld_q  <= 1'b0;
      rd_pvld_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      used_q    <= used_d;
      s1_vld_q  <= s1_vld_d;
      rd_pvld_q <= rd_pvld_d;
    end
  end

  // Output drive: handshakes, RAM ports and power-bus passthrough.
  assign bus.wr_prdy           = wr_prdy_c;
  assign bus.rd_pvld           = rd_pvld_q;
  assign bus.rd_pd             = bus.ram_dout;

  assign bus.ram_ra            = rptr_q;
  assign bus.ram_re            = re;
  assign bus.ram_ore           = ore;

  assign bus.ram_wa            = wptr_q;
  assign bus.ram_we            = we;
  assign bus.ram_di            = bus.wr_pd;
  assign bus.ram_byp_sel       = byp;
  assign bus.ram_dbyp          = bus.wr_pd;

  assign bus.ram_pwrbus_ram_pd = bus.pwrbus_ram_pd;

  // Structural invariants of the read pipeline and occupancy counter.
  a_re_protects_latch : assert property (
    @(posedge clk) disable iff (rst) (re & s1_vld_q) |-> ore);
  a_used_bounded : assert property (
    @(posedge clk) disable iff (rst) used_q <= USED_FULL);
  a_ptrs_in_range : assert property (
    @(posedge clk) disable iff (rst) (wptr_q <= PTR_LAST) && (rptr_q <= PTR_LAST));

endmodule

// File: tb/tb_sa_fifo_ctrl_19x4.sv
// tb_sa_fifo_ctrl_19x4: bench for the 19x4 FIFO controller with a
// behavioural model of the external RAM and a queue-based FIFO reference.
module tb_sa_fifo_ctrl_19x4;

  localparam int DEPTH = 19;
  localparam int CAP   = 20;
`ifdef SA_FIFO_CTRL_BYPASS_EN
  // Further clock edges after the accepting edge before rd_pvld is seen.
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sa_fifo_ctrl_19x4_if bus ();

  sa_fifo_ctrl_19x4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- external RAM model ----------------
  logic [3:0] mem [0:31];
  logic [4:0] ra_q;

  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re === 1'b1) ra_q <= bus.ram_ra;
    if (bus.ram_ore === 1'b1)
      bus.ram_dout <= (bus.ram_byp_sel === 1'b1) ? bus.ram_dbyp : mem[ra_q];
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int re_cnt   = 0;
  int pop_cnt  = 0;
  bit s1_m     = 1'b0;   // RAM has a latched address not yet read out

  bit         m_wr_fire, m_rd_fire, m_out_free, m_exp_prdy, m_exp_byp;
  int         m_held;
  logic [4:0] m_exp_addr;

  // Reference FIFO: tracks every accepted beat, checks order, capacity,
  // bypass use and RAM addressing from the observed handshakes.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
      wr_cnt = 0;
      re_cnt = 0;
      s1_m   = 1'b0;
      checks++;
      if (bus.wr_prdy !== 1'b0 || bus.rd_pvld !== 1'b0) begin
        failures++;
        $display("FAIL rst_outputs wr_prdy=%b rd_pvld=%b want 0 0", bus.wr_prdy, bus.rd_pvld);
      end
    end else begin
      m_wr_fire  = (bus.wr_pvld === 1'b1) && (bus.wr_prdy === 1'b1);
      m_rd_fire  = (bus.rd_pvld === 1'b1) && (bus.rd_prdy === 1'b1);
      m_out_free = (bus.rd_pvld !== 1'b1) || (bus.rd_prdy === 1'b1);
      // Entries not sitting in the output register must stay below 19.
      m_held     = exp_q.size() - ((bus.rd_pvld === 1'b1) ? 1 : 0);
      m_exp_prdy = (m_held < DEPTH);
      checks++;
      if (bus.wr_prdy !== m_exp_prdy) begin
        failures++;
        $display("FAIL capacity wr_prdy=%b want %b (stored=%0d)", bus.wr_prdy, m_exp_prdy, exp_q.size());
      end
`ifdef SA_FIFO_CTRL_BYPASS_EN
      m_exp_byp = m_wr_fire && (m_held == 0) && m_out_free;
`else
      m_exp_byp = 1'b0;
`endif
      checks++;
      if (bus.ram_byp_sel !== m_exp_byp) begin
        failures++;
        $display("FAIL byp_sel got=%b want=%b", bus.ram_byp_sel, m_exp_byp);
      end
      checks++;
      if (bus.ram_we !== (m_wr_fire && !m_exp_byp)) begin
        failures++;
        $display("FAIL ram_we got=%b want=%b", bus.ram_we, (m_wr_fire && !m_exp_byp));
      end
      if (bus.rd_pvld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_valid rd_pd=%h with nothing stored", bus.rd_pd);
        end else if (bus.rd_pd !== exp_q[0]) begin
          failures++;
          $display("FAIL rd_pd got=%h want=%h", bus.rd_pd, exp_q[0]);
        end
      end
      if (bus.ram_re === 1'b1) begin
        checks++;
        if (s1_m && bus.ram_ore !== 1'b1) begin
          failures++;
          $display("FAIL re_protect ram_re=1 while latched address unread, ore=%b", bus.ram_ore);
        end
        m_exp_addr = 5'(re_cnt % DEPTH);
        checks++;
        if (bus.ram_ra !== m_exp_addr) begin
          failures++;
          $display("FAIL ram_ra got=%0d want=%0d", bus.ram_ra, m_exp_addr);
        end
        re_cnt++;
      end
      if (bus.ram_ore === 1'b1 && bus.ram_byp_sel !== 1'b1) begin
        checks++;
        if (!s1_m) begin
          failures++;
          $display("FAIL ore_unlatched ram_ore=1 got=%b want latched address", s1_m);
        end
      end
      if (bus.ram_we === 1'b1) begin
        m_exp_addr = 5'(wr_cnt % DEPTH);
        checks++;
        if (bus.ram_wa !== m_exp_addr) begin
          failures++;
          $display("FAIL ram_wa got=%0d want=%0d", bus.ram_wa, m_exp_addr);
        end
        wr_cnt++;
      end
      if (m_wr_fire) begin
        checks++;
        if (bus.ram_di !== bus.wr_pd || bus.ram_dbyp !== bus.wr_pd) begin
          failures++;
          $display("FAIL wr_data di=%h dbyp=%h want %h", bus.ram_di, bus.ram_dbyp, bus.wr_pd);
        end
      end
      s1_m = (bus.ram_re === 1'b1) ||
             (s1_m && !((bus.ram_ore === 1'b1) && (bus.ram_byp_sel !== 1'b1)));
      if (m_rd_fire && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (m_wr_fire) exp_q.push_back(bus.wr_pd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for rd_pvld, returning the number of extra edges spent.
  task automatic wait_valid(output int k);
    k = 0;
    while (bus.rd_pvld !== 1'b1 && k < 12) begin
      tick();
      k++;
    end
  endtask

  task automatic drain_all(input string name);
    int n;
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.rd_pvld === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.rd_pvld !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain left=%0d rd_pvld=%b want 0 0", name, exp_q.size(), bus.rd_pvld);
    end
  endtask

  task automatic test_reset();
    logic [31:0] pwr;
    rst = 1'b1;
    pwr = $urandom;
    bus.pwrbus_ram_pd = pwr;
    repeat (3) tick();
    checks++;
    if (bus.ram_pwrbus_ram_pd !== pwr) begin
      failures++;
      $display("FAIL pwrbus got=%h want=%h", bus.ram_pwrbus_ram_pd, pwr);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bus.wr_prdy !== 1'b1 || bus.rd_pvld !== 1'b0 || bus.ram_re !== 1'b0 || bus.ram_ore !== 1'b0) begin
      failures++;
      $display("FAIL post_reset wr_prdy=%b rd_pvld=%b re=%b ore=%b want 1 0 0 0",
               bus.wr_prdy, bus.rd_pvld, bus.ram_re, bus.ram_ore);
    end
    pwr = ~pwr;
    bus.pwrbus_ram_pd = pwr;
    #1;
    checks++;
    if (bus.ram_pwrbus_ram_pd !== pwr) begin
      failures++;
      $display("FAIL pwrbus_change got=%h want=%h", bus.ram_pwrbus_ram_pd, pwr);
    end
  endtask

  task automatic test_single_push();
    int k;
    bus.rd_prdy = 1'b1;
    repeat (2) tick();
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'hA;
    tick();
    bus.wr_pvld = 1'b0;
    wait_valid(k);
    checks++;
    if (k != EXP_LAT) begin
      failures++;
      $display("FAIL single_latency edges=%0d want=%0d", k, EXP_LAT);
    end
    checks++;
    if (bus.rd_pd !== 4'hA) begin
      failures++;
      $display("FAIL single_data got=%h want=a", bus.rd_pd);
    end
    repeat (3) tick();
    checks++;
    if (bus.rd_pvld !== 1'b0 || bus.wr_prdy !== 1'b1) begin
      failures++;
      $display("FAIL single_empty rd_pvld=%b wr_prdy=%b want 0 1", bus.rd_pvld, bus.wr_prdy);
    end
  endtask

  task automatic test_fill_full();
    int acc;
    acc = 0;
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 25; i++) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = 4'(i);
      @(negedge clk);
      if (bus.wr_prdy === 1'b1) acc++;
      tick();
    end
    bus.wr_pvld = 1'b0;
    repeat (3) tick();
    checks++;
    if (acc != CAP) begin
      failures++;
      $display("FAIL full_accepted got=%0d want=%0d", acc, CAP);
    end
    checks++;
    if (bus.wr_prdy !== 1'b0 || bus.rd_pvld !== 1'b1 || bus.rd_pd !== 4'h0) begin
      failures++;
      $display("FAIL full_state wr_prdy=%b rd_pvld=%b rd_pd=%h want 0 1 0",
               bus.wr_prdy, bus.rd_pvld, bus.rd_pd);
    end
  endtask

  task automatic test_drain_from_full();
    int p0;
    p0 = pop_cnt;
    bus.rd_prdy = 1'b1;
    tick();
    checks++;
    if (bus.wr_prdy !== 1'b1) begin
      failures++;
      $display("FAIL full_reopen wr_prdy=%b want 1", bus.wr_prdy);
    end
    repeat (CAP - 1) tick();
    checks++;
    if ((pop_cnt - p0) != CAP || bus.rd_pvld !== 1'b0) begin
      failures++;
      $display("FAIL drain_rate pops=%0d rd_pvld=%b want %0d 0", pop_cnt - p0, bus.rd_pvld, CAP);
    end
  endtask

  task automatic test_stream();
    int  n, cyc;
    bit  acc;
    n = 0;
    cyc = 0;
    while (n < 200 && cyc < 5000) begin
      if (bus.wr_pvld !== 1'b1 && $urandom_range(0, 3) != 0) begin
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = 4'($urandom);
      end
      bus.rd_prdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = (bus.wr_pvld === 1'b1) && (bus.wr_prdy === 1'b1);
      tick();
      if (acc) begin
        n++;
        bus.wr_pvld = 1'b0;
      end
      cyc++;
    end
    bus.wr_pvld = 1'b0;
    checks++;
    if (n != 200) begin
      failures++;
      $display("FAIL stream_accepted got=%0d want=200", n);
    end
    drain_all("stream");
  endtask

  task automatic test_reset_midstream();
    int k;
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = 4'(i + 9);
      tick();
    end
    bus.wr_pvld = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.rd_pvld !== 1'b1 || bus.wr_prdy !== 1'b1 || bus.rd_pd !== 4'h9) begin
      failures++;
      $display("FAIL pre_reset rd_pvld=%b wr_prdy=%b rd_pd=%h want 1 1 9",
               bus.rd_pvld, bus.wr_prdy, bus.rd_pd);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rd_pvld !== 1'b0 || bus.wr_prdy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset rd_pvld=%b wr_prdy=%b want 0 0", bus.rd_pvld, bus.wr_prdy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.wr_prdy !== 1'b1 || bus.rd_pvld !== 1'b0) begin
      failures++;
      $display("FAIL reset_release wr_prdy=%b rd_pvld=%b want 1 0", bus.wr_prdy, bus.rd_pvld);
    end
    bus.rd_prdy = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h3;
    tick();
    bus.wr_pvld = 1'b0;
    wait_valid(k);
    checks++;
    if (k != EXP_LAT || bus.rd_pd !== 4'h3) begin
      failures++;
      $display("FAIL fresh_push edges=%0d rd_pd=%h want %0d 3", k, bus.rd_pd, EXP_LAT);
    end
    drain_all("reset");
  endtask

  task automatic test_bypass();
    bus.rd_prdy = 1'b1;
    tick();
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h5;
    @(negedge clk);
`ifdef SA_FIFO_CTRL_BYPASS_EN
    checks++;
    if (bus.ram_byp_sel !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_ore !== 1'b1) begin
      failures++;
      $display("FAIL bypass_first byp=%b we=%b ore=%b want 1 0 1", bus.ram_byp_sel, bus.ram_we, bus.ram_ore);
    end
    tick();
    bus.wr_pvld = 1'b0;
    checks++;
    if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== 4'h5) begin
      failures++;
      $display("FAIL bypass_out rd_pvld=%b rd_pd=%h want 1 5", bus.rd_pvld, bus.rd_pd);
    end
    bus.rd_prdy = 1'b0;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h6;
    tick();
    bus.wr_pvld = 1'b0;
    repeat (2) tick();
    bus.rd_prdy = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h7;
    @(negedge clk);
    checks++;
    if (bus.ram_byp_sel !== 1'b0 || bus.ram_we !== 1'b1) begin
      failures++;
      $display("FAIL bypass_busy byp=%b we=%b want 0 1", bus.ram_byp_sel, bus.ram_we);
    end
`else
    checks++;
    if (bus.ram_byp_sel !== 1'b0 || bus.ram_we !== 1'b1) begin
      failures++;
      $display("FAIL no_bypass byp=%b we=%b want 0 1", bus.ram_byp_sel, bus.ram_we);
    end
`endif
    tick();
    bus.wr_pvld = 1'b0;
    drain_all("bypass");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b1;
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = 4'h0;
    bus.rd_prdy = 1'b0;
    bus.pwrbus_ram_pd = 32'h0;
    test_reset();
    test_single_push();
    test_fill_full();
    test_drain_from_full();
    test_stream();
    test_reset_midstream();
    test_bypass();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
